code_rom_loader: RTL

Upstream feeder for the debug harness code ROM. It accepts a length-prefixed program image as a byte stream over a valid/ready handshake and drives the harness ROM-programming pins: clear strobe, program mode, byte address and byte data. After the image it appends the 4-byte end meta-instruction, then releases program mode and reports done or error. The host then issues debug commands.

---
 rtl/code_rom_loader.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/code_rom_loader.sv
// code_rom_loader
//
// Feeds the debug harness code ROM from a length-prefixed byte stream.
// The stream starts with a 16-bit little-endian image length, followed by
// the image bytes. Each image byte is written to the next ROM address.
// After the image, the loader writes the 4-byte end meta-instruction
// (END_WORD, little-endian) at addresses len..len+3. It then drops program
// mode and reports load_done. A bad length reports load_error instead.
//
// Optional build macro: LOADER_CHECKSUM_EN
//   When defined, one extra stream byte follows the image. It must equal the
//   XOR of all image bytes; a mismatch aborts the load before the terminator
//   is written.
//
// Ports:
//   clk              clock, same domain as the harness ROM write port
//   reset_n          asynchronous active-low reset
//   start            one-cycle pulse, begins a load when not busy
//   in_valid/in_data stream byte offered by upstream
//   in_ready         loader consumes in_data this cycle
//   rom_reset_n      active-low ROM clear strobe (one cycle per load)
//   rom_program_mode harness program_rom_mode
//   rom_addr         harness code_rom_addr_in
//   rom_data         harness code_rom_data_in
//   byte_count       image bytes written so far
//   load_done        level, load completed successfully
//   load_error       level, load aborted

module code_rom_loader #(
    parameter int          ADDR_W    = 12,
    parameter int          MAX_BYTES = 512,
    parameter logic [31:0] END_WORD  = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              rom_reset_n,
    output logic              rom_program_mode,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [7:0]        rom_data,
    output logic [ADDR_W:0]   byte_count,
    output logic              load_done,
    output logic              load_error
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_TERM,
        ST_DONE,
        ST_ERROR
`ifdef LOADER_CHECKSUM_EN
        ,
        ST_CHK
`endif
    } state_t;

    state_t state_q, state_d;

    logic [15:0]       len_q, len_d;
    logic [2:0]        term_idx_q, term_idx_d;

    logic              in_ready_d;
    logic              rom_reset_n_d;
    logic              rom_program_mode_d;
    logic [ADDR_W-1:0] rom_addr_d;
    logic [7:0]        rom_data_d;
    logic [ADDR_W:0]   byte_count_d;
    logic              load_done_d;
    logic              load_error_d;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        chk_q, chk_d;
`endif

    logic              accept;
    logic [15:0]       len_new;
    logic              len_bad;
    logic [15:0]       count_inc;
    logic [7:0]        term_byte;

    // in_ready is registered, so it already reflects the current state and
    // can be used directly to qualify a transfer.
    assign accept    = in_valid && in_ready;
    assign len_new   = {in_data, len_q[7:0]};
    assign len_bad   = (len_new == 16'd0) || (len_new > 16'(MAX_BYTES)) ||
                       (len_new[1:0] != 2'b00);
    assign count_inc = 16'(byte_count) + 16'd1;

    // Terminator byte selected by the low two bits of the TERM index.
    always_comb begin
        case (term_idx_q[1:0])
            2'd0:    term_byte = END_WORD[7:0];
            2'd1:    term_byte = END_WORD[15:8];
            2'd2:    term_byte = END_WORD[23:16];
            default: term_byte = END_WORD[31:24];
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            len_q            <= '0;
            term_idx_q       <= '0;
            in_ready         <= 1'b0;
            rom_reset_n      <= 1'b1;
            rom_program_mode <= 1'b0;
            rom_addr         <= '0;
            rom_data         <= '0;
            byte_count       <= '0;
            load_done        <= 1'b0;
            load_error       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_q            <= '0;
`endif
        end else begin
            state_q          <= state_d;
            len_q            <= len_d;
            term_idx_q       <= term_idx_d;
            in_ready         <= in_ready_d;
            rom_reset_n      <= rom_reset_n_d;
            rom_program_mode <= rom_program_mode_d;
            rom_addr         <= rom_addr_d;
            rom_data         <= rom_data_d;
            byte_count       <= byte_count_d;
            load_done        <= load_done_d;
            load_error       <= load_error_d;
`ifdef LOADER_CHECKSUM_EN
            chk_q            <= chk_d;
`endif
        end
    end

    // Next-state and next-output logic. Outputs are computed for the state
    // being entered, so every registered output matches its state.
    always_comb begin
        state_d            = state_q;
        len_d              = len_q;
        term_idx_d         = term_idx_q;
        in_ready_d         = 1'b0;
        rom_reset_n_d      = 1'b1;
        rom_program_mode_d = rom_program_mode;
        rom_addr_d         = rom_addr;
        rom_data_d         = rom_data;
        byte_count_d       = byte_count;
        load_done_d        = load_done;
        load_error_d       = load_error;
`ifdef LOADER_CHECKSUM_EN
        chk_d              = chk_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d            = ST_CLEAR;
                    rom_reset_n_d      = 1'b0;
                    rom_program_mode_d = 1'b0;
                    byte_count_d       = '0;
                    load_done_d        = 1'b0;
                    load_error_d       = 1'b0;
                    term_idx_d         = '0;
`ifdef LOADER_CHECKSUM_EN
                    chk_d              = '0;
`endif
                end
            end

            ST_CLEAR: begin
                state_d    = ST_LEN_LO;
                in_ready_d = 1'b1;
            end

            ST_LEN_LO: begin
                in_ready_d = 1'b1;
                if (accept) begin
                    len_d[7:0] = in_data;
                    state_d    = ST_LEN_HI;
                end
            end

            ST_LEN_HI: begin
                in_ready_d = 1'b1;
                if (accept) begin
                    len_d = len_new;
                    if (len_bad) begin
                        state_d            = ST_ERROR;
                        in_ready_d         = 1'b0;
                        load_error_d       = 1'b1;
                        rom_program_mode_d = 1'b0;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                in_ready_d = 1'b1;
                if (accept) begin
                    rom_addr_d         = ADDR_W'(byte_count);
                    rom_data_d         = in_data;
                    rom_program_mode_d = 1'b1;
                    byte_count_d       = (ADDR_W+1)'(count_inc);
`ifdef LOADER_CHECKSUM_EN
                    chk_d              = chk_q ^ in_data;
`endif
                    if (count_inc == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d    = ST_CHK;
`else
                        state_d    = ST_TERM;
                        in_ready_d = 1'b0;
                        term_idx_d = '0;
`endif
                    end
                end
            end

`ifdef LOADER_CHECKSUM_EN
            // The last image byte stays on the ROM pins while waiting for
            // the checksum; rewriting it is harmless.
            ST_CHK: begin
                in_ready_d = 1'b1;
                if (accept) begin
                    in_ready_d = 1'b0;
                    if (in_data == chk_q) begin
                        state_d    = ST_TERM;
                        term_idx_d = '0;
                    end else begin
                        state_d            = ST_ERROR;
                        load_error_d       = 1'b1;
                        rom_program_mode_d = 1'b0;
                    end
                end
            end
`endif

            // Index 0..3 writes one terminator byte per cycle; index 4 ends
            // program mode. byte_count stays at the image length.
            ST_TERM: begin
                if (term_idx_q[2]) begin
                    state_d            = ST_DONE;
                    rom_program_mode_d = 1'b0;
                    load_done_d        = 1'b1;
                end else begin
                    rom_addr_d         = ADDR_W'(len_q) + ADDR_W'(term_idx_q);
                    rom_data_d         = term_byte;
                    rom_program_mode_d = 1'b1;
                    term_idx_d         = term_idx_q + 3'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
